// File: rtl/pcoeff_acc_pkg.sv
// Shared widths and defaults for the multi-channel pcoeff accumulator and its result FIFO.
package pcoeff_acc_pkg;

  localparam int DEF_MAX_CONNECT = 35;
  localparam int DEF_COUNT_WIDTH = 13;
  localparam int CONNECT_W       = 6;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int sum_width(input int count_width, input int max_connect);
    return count_width + max_connect + 1;
  endfunction

  // Result entry layout, MSB first: {channel, sum, count, error}.
  function automatic int entry_width(input int ch_w, input int sum_w, input int count_w);
    return ch_w + sum_w + count_w + 1;
  endfunction

endpackage

// File: rtl/pcoeff_result_fifo.sv
// Closed-batch result FIFO: power-of-two depth, registered full/empty flags.
module pcoeff_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW  = $clog2(DEPTH);
  localparam int UW  = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]    used_q, used_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    // Pointers wrap for free because DEPTH is a power of two.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    used_d   = used_q + UW'(do_push) - UW'(do_pop);
    full_d   = (used_d == UW'(DEPTH));
    empty_d  = (used_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/multi_channel_pcoeff_accumulator.sv
// Per-channel accumulation of 2^connect_count into batches, closed batches queued in a FIFO.
// Optional macro PCOEFF_ACC_RANGE_CHECK_EN rejects counts above MAX_CONNECT from the sum.
module multi_channel_pcoeff_accumulator
  import pcoeff_acc_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int MAX_CONNECT = DEF_MAX_CONNECT,
  parameter int FIFO_DEPTH  = 4,
  localparam int CH_W  = ch_width(CHANNELS),
  localparam int SUM_W = sum_width(COUNT_WIDTH, MAX_CONNECT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH_W-1:0]        in_channel,
  input  logic [CONNECT_W-1:0]   in_connect_count,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH_W-1:0]        out_channel,
  output logic [SUM_W-1:0]       out_sum,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_error,
  output logic                   err_sticky
);

  localparam int EW = entry_width(CH_W, SUM_W, COUNT_WIDTH);

  logic [SUM_W-1:0]       sum_q   [CHANNELS];
  logic [SUM_W-1:0]       sum_d   [CHANNELS];
  logic [COUNT_WIDTH-1:0] count_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] count_d [CHANNELS];
  logic [CHANNELS-1:0]    err_q, err_d;
  logic                   err_sticky_q, err_sticky_d;

  logic                   ch_ok, accept, range_bad, push;
  logic [SUM_W-1:0]       contrib, new_sum;
  logic [COUNT_WIDTH-1:0] new_count;
  logic                   new_err;
  logic [EW-1:0]          push_entry, head_entry;
  logic                   fifo_full, fifo_empty;

  always_comb begin
    sum_d        = sum_q;
    count_d      = count_q;
    err_d        = err_q;
    new_sum      = '0;
    new_count    = '0;
    new_err      = 1'b0;
    ch_ok        = (int'(in_channel) < CHANNELS);
    accept       = in_valid && in_ready && ch_ok;
`ifdef PCOEFF_ACC_RANGE_CHECK_EN
    range_bad    = (int'(in_connect_count) > MAX_CONNECT);
`else
    range_bad    = 1'b0;
`endif
    // A shift past SUM_W yields zero, so oversized counts without the check add nothing.
    contrib      = range_bad ? '0 : (SUM_W'(1) << in_connect_count);

    for (int c = 0; c < CHANNELS; c++) begin
      if (in_channel == CH_W'(c)) begin
        new_sum   = sum_q[c] + contrib;
        new_count = count_q[c] + 1'b1;
        new_err   = err_q[c] | range_bad;
        if (accept) begin
          sum_d[c]   = in_last ? '0 : new_sum;
          count_d[c] = in_last ? '0 : new_count;
          err_d[c]   = in_last ? 1'b0 : new_err;
        end
      end
    end

    push         = accept && in_last;
    push_entry   = {in_channel, new_sum, new_count, new_err};
    err_sticky_d = err_sticky_q | (in_valid && !ch_ok) | (accept && range_bad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c]   <= '0;
        count_q[c] <= '0;
      end
      err_q        <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      sum_q        <= sum_d;
      count_q      <= count_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  pcoeff_result_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_valid && out_ready),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields are masked while empty so unreset storage never leaks to the outputs.
  assign out_valid  = !fifo_empty;
  assign in_ready   = !fifo_full;
  assign err_sticky = err_sticky_q;
  assign {out_channel, out_sum, out_count, out_error} = out_valid ? head_entry : '0;

endmodule

// File: tb/tb_multi_channel_pcoeff_accumulator.sv
// Directed bench for multi_channel_pcoeff_accumulator with default parameters.
module tb_multi_channel_pcoeff_accumulator;

  localparam int SW = 49;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [0:0]    in_channel;
  logic [5:0]    in_connect_count;
  logic          out_valid, out_ready;
  logic [0:0]    out_channel;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_error, err_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  multi_channel_pcoeff_accumulator dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_channel       (in_channel),
    .in_connect_count (in_connect_count),
    .in_last          (in_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_channel      (out_channel),
    .out_sum          (out_sum),
    .out_count        (out_count),
    .out_error        (out_error),
    .err_sticky       (err_sticky)
  );

  always #5 clk = ~clk;

  // Presents one input for one rising edge; returns #1 after that edge.
  task automatic send(input logic ch, input int cnt, input logic last);
    @(negedge clk);
    in_valid         = 1'b1;
    in_channel       = ch;
    in_connect_count = 6'(cnt);
    in_last          = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Samples the head at the falling edge, then pops it over the next rising edge.
  task automatic pop_entry(output logic v, output logic ch, output logic [SW-1:0] s,
                           output logic [CW-1:0] c, output logic e);
    @(negedge clk);
    v  = out_valid;
    ch = out_channel;
    s  = out_sum;
    c  = out_count;
    e  = out_error;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_channel, out_sum, out_count, out_error, err_sticky} !==
        {1'b0, 1'b1, 1'b0, {SW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b ready=%b ch=%0d sum=%0d cnt=%0d err=%b sticky=%b, want 0 1 0 0 0 0 0",
               out_valid, in_ready, out_channel, out_sum, out_count, out_error, err_sticky);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_batch();
    logic v, ch, e;
    logic [SW-1:0] s;
    logic [CW-1:0] c;
    send(1'b0, 3, 1'b0);
    send(1'b0, 5, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_open_valid: got %b want 0", out_valid);
    end
    send(1'b0, 0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_latency: got out_valid=%b want 1", out_valid);
    end
    pop_entry(v, ch, s, c, e);
    n_cmp++;
    if ({v, ch, s, c, e} !== {1'b1, 1'b0, SW'(41), CW'(3), 1'b0}) begin
      n_bad++;
      $display("FAIL single_entry: got v=%b ch=%0d sum=%0d cnt=%0d err=%b want 1 0 41 3 0", v, ch, s, c, e);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drained: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_interleave();
    logic v, ch, e;
    logic [SW-1:0] s;
    logic [CW-1:0] c;
    send(1'b1, 2, 1'b0);
    send(1'b0, 1, 1'b0);
    send(1'b1, 4, 1'b0);
    send(1'b0, 1, 1'b1);
    send(1'b1, 6, 1'b1);
    pop_entry(v, ch, s, c, e);
    n_cmp++;
    if ({v, ch, s, c, e} !== {1'b1, 1'b0, SW'(4), CW'(2), 1'b0}) begin
      n_bad++;
      $display("FAIL interleave_ch0: got v=%b ch=%0d sum=%0d cnt=%0d err=%b want 1 0 4 2 0", v, ch, s, c, e);
    end
    pop_entry(v, ch, s, c, e);
    n_cmp++;
    if ({v, ch, s, c, e} !== {1'b1, 1'b1, SW'(84), CW'(3), 1'b0}) begin
      n_bad++;
      $display("FAIL interleave_ch1: got v=%b ch=%0d sum=%0d cnt=%0d err=%b want 1 1 84 3 0", v, ch, s, c, e);
    end
  endtask

  task automatic test_range();
    logic v, ch, e;
    logic [SW-1:0] s, exp_sum;
    logic [CW-1:0] c;
    logic exp_err;
`ifdef PCOEFF_ACC_RANGE_CHECK_EN
    exp_sum = SW'(4);
    exp_err = 1'b1;
`else
    exp_sum = (SW'(1) << 40) + SW'(4);
    exp_err = 1'b0;
`endif
    send(1'b1, 40, 1'b0);
    send(1'b1, 2, 1'b1);
    pop_entry(v, ch, s, c, e);
    n_cmp++;
    if ({v, ch, s, c, e} !== {1'b1, 1'b1, exp_sum, CW'(2), exp_err}) begin
      n_bad++;
      $display("FAIL range_entry: got v=%b ch=%0d sum=%0d cnt=%0d err=%b want 1 1 %0d 2 %b",
               v, ch, s, c, e, exp_sum, exp_err);
    end
    n_cmp++;
    if (err_sticky !== exp_err) begin
      n_bad++;
      $display("FAIL range_sticky: got %b want %b", err_sticky, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic v, ch, e;
    logic [SW-1:0] s;
    logic [CW-1:0] c;
    logic [SW-1:0] exp_s [4];
    logic          exp_ch[4];
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'(i % 2), i, 1'b1);
      n_cmp++;
      if (in_ready !== (i < 3)) begin
        n_bad++;
        $display("FAIL fill_ready_%0d: got in_ready=%b want %b", i, in_ready, i < 3);
      end
    end
    // Blocked by the full FIFO; must not be accepted.
    send(1'b0, 9, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_channel, out_sum} !== {1'b1, 1'b0, SW'(1)}) begin
      n_bad++;
      $display("FAIL hold_head: got v=%b ch=%0d sum=%0d want 1 0 1", out_valid, out_channel, out_sum);
    end
    pop_entry(v, ch, s, c, e);
    n_cmp++;
    if ({v, ch, s, in_ready} !== {1'b1, 1'b0, SW'(1), 1'b1}) begin
      n_bad++;
      $display("FAIL first_pop: got v=%b ch=%0d sum=%0d ready=%b want 1 0 1 1", v, ch, s, in_ready);
    end
    // Simultaneous push and pop.
    @(negedge clk);
    in_valid = 1'b1; in_channel = 1'b0; in_connect_count = 6'd10; in_last = 1'b1;
    out_ready = 1'b1;
    n_cmp++;
    if ({out_channel, out_sum} !== {1'b1, SW'(2)}) begin
      n_bad++;
      $display("FAIL pushpop_head: got ch=%0d sum=%0d want 1 2", out_channel, out_sum);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL pushpop_ready: got in_ready=%b want 1", in_ready);
    end
    send(1'b1, 11, 1'b1);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL refill_ready: got in_ready=%b want 0", in_ready);
    end
    exp_ch[0] = 1'b0; exp_s[0] = SW'(4);
    exp_ch[1] = 1'b1; exp_s[1] = SW'(8);
    exp_ch[2] = 1'b0; exp_s[2] = SW'(1024);
    exp_ch[3] = 1'b1; exp_s[3] = SW'(2048);
    for (int i = 0; i < 4; i++) begin
      pop_entry(v, ch, s, c, e);
      n_cmp++;
      if ({v, ch, s, c} !== {1'b1, exp_ch[i], exp_s[i], CW'(1)}) begin
        n_bad++;
        $display("FAIL drain_%0d: got v=%b ch=%0d sum=%0d cnt=%0d want 1 %0d %0d 1",
                 i, v, ch, s, c, exp_ch[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic v, ch, e;
    logic [SW-1:0] s;
    logic [CW-1:0] c;
    send(1'b0, 1, 1'b1);
    send(1'b1, 1, 1'b1);
    send(1'b0, 3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_sum, out_count, err_sticky} !==
        {1'b0, 1'b1, {SW{1'b0}}, {CW{1'b0}}, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset_state: got v=%b ready=%b sum=%0d cnt=%0d sticky=%b want 0 1 0 0 0",
               out_valid, in_ready, out_sum, out_count, err_sticky);
    end
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 7, 1'b1);
    pop_entry(v, ch, s, c, e);
    n_cmp++;
    if ({v, ch, s, c, e} !== {1'b1, 1'b0, SW'(128), CW'(1), 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset_batch: got v=%b ch=%0d sum=%0d cnt=%0d err=%b want 1 0 128 1 0", v, ch, s, c, e);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_drained: got out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    rst              = 1'b1;
    in_valid         = 1'b0;
    in_channel       = 1'b0;
    in_connect_count = 6'd0;
    in_last          = 1'b0;
    out_ready        = 1'b0;
    test_reset();
    test_single_batch();
    test_interleave();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
